// File: rtl/clkstep_ctl_pkg.sv
// Shared definitions for the run/halt/single-step clock controller.
package clkstep_ctl_pkg;

    // Controller state encoding; 2'b11 is illegal and treated as HALT.
    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_e;

    // Stable cycles needed before a button level change is accepted.
    localparam int unsigned DEB_CYC_DEF = 16;

endpackage : clkstep_ctl_pkg

// File: rtl/clkstep_ctl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, debounce filter, accepted level
// and a one-cycle pulse on each accepted 0->1 transition.
module btn_debounce
    import clkstep_ctl_pkg::*;
#(
    parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned CW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;

    logic          meta_q;
    logic          sync_q;
    logic          acc_q,   acc_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          pulse_q, pulse_d;

    // Filter: count consecutive mismatch cycles, flip the accepted level
    // on the DEB_CYC-th one; any matching cycle restarts the count.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (sync_q != acc_q) begin
            if (cnt_q == CW'(DEB_CYC - 1)) begin
                acc_d   = sync_q;
                pulse_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchronizer and filter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule : btn_debounce

// File: rtl/clkstep_ctl.sv
// Run/halt/single-step controller producing the registered edge-enable for
// the downstream positive-edge clock gate, plus a count of passed edges.
module clkstep_ctl
    import clkstep_ctl_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEB_CYC = DEB_CYC_DEF,
    parameter int unsigned EDGE_W  = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_btn,
    input  logic [CNT_W-1:0]  step_n,
    input  logic              cpu_hlt,
    output logic              en,
    output logic              running,
    output logic [EDGE_W-1:0] edge_cnt
);

    state_e             state_q, state_d;
    logic               en_q,    en_d;
    logic               run_q,   run_d;
    logic [CNT_W-1:0]   rem_q,   rem_d;
    logic [EDGE_W-1:0]  edge_q;
    logic               hlt_meta_q;
    logic               hlt_s;
    logic               step_pulse;

    btn_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_step_deb (
        .clk_i   (clk),
        .rst_ni  (nrst),
        .btn_i   (step_btn),
        .pulse_o (step_pulse)
    );

    // CPU halt request synchronizer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hlt_meta_q <= 1'b0;
            hlt_s      <= 1'b0;
        end else begin
            hlt_meta_q <= cpu_hlt;
            hlt_s      <= hlt_meta_q;
        end
    end

    // Next state and next enable, in priority order: halt_req, then per state.
    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        rem_d   = rem_q;
        if (halt_req) begin
            state_d = ST_HALT;
            rem_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hlt_s) begin
                        state_d = ST_HALT;
                    end else begin
                        en_d = 1'b1;
                    end
                end
                ST_HALT: begin
                    if (run_req && !hlt_s) begin
                        state_d = ST_RUN;
                        en_d    = 1'b1;
                    end else if (step_pulse) begin
                        state_d = ST_STEP;
                        rem_d   = (step_n == '0) ? CNT_W'(1) : step_n;
                        en_d    = 1'b1;
                    end
                end
                ST_STEP: begin
                    // rem_q counts the enable cycles still owed, including the
                    // one already registered; the burst ends as it hits zero.
                    if (hlt_s || rem_q <= CNT_W'(1)) begin
                        state_d = ST_HALT;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                        en_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_HALT;
                    rem_d   = '0;
                end
            endcase
        end
        run_d = (state_d != ST_HALT);
    end

    // Controller registers; reset drops en without waiting for a clock edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_HALT;
            en_q    <= 1'b0;
            run_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            run_q   <= run_d;
            rem_q   <= rem_d;
        end
    end

    // Passed-edge counter: one count per gated edge, wrapping.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            edge_q <= '0;
        end else if (en_q) begin
            edge_q <= edge_q + EDGE_W'(1);
        end
    end

    assign en       = en_q;
    assign running  = run_q;
    assign edge_cnt = edge_q;

endmodule : clkstep_ctl

// File: tb/tb_clkstep_ctl.sv
// Directed bench for clkstep_ctl: inputs driven and outputs sampled on the
// falling edge; expected values are hand-derived cycle counts.
module tb_clkstep_ctl;

    logic        clk;
    logic        nrst;
    logic        run_req;
    logic        halt_req;
    logic        step_btn;
    logic [7:0]  step_n;
    logic        cpu_hlt;
    logic        en;
    logic        running;
    logic [15:0] edge_cnt;

    logic        run_req4;
    logic        en4;
    logic        running4;
    logic [3:0]  edge_cnt4;

    int vectors;
    int miscompares;

    clkstep_ctl #(
        .CNT_W   (8),
        .DEB_CYC (16),
        .EDGE_W  (16)
    ) u_dut (
        .clk      (clk),
        .nrst     (nrst),
        .run_req  (run_req),
        .halt_req (halt_req),
        .step_btn (step_btn),
        .step_n   (step_n),
        .cpu_hlt  (cpu_hlt),
        .en       (en),
        .running  (running),
        .edge_cnt (edge_cnt)
    );

    clkstep_ctl #(
        .CNT_W   (8),
        .DEB_CYC (16),
        .EDGE_W  (4)
    ) u_dut4 (
        .clk      (clk),
        .nrst     (nrst),
        .run_req  (run_req4),
        .halt_req (1'b0),
        .step_btn (1'b0),
        .step_n   (8'd0),
        .cpu_hlt  (1'b0),
        .en       (en4),
        .running  (running4),
        .edge_cnt (edge_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Press at N0: accepted pulse at edge 18, enable from edge 19 for n_en cycles.
    task automatic do_step(input logic [7:0] n, input int n_en, input logic [15:0] exp_cnt);
        step_n   = n;
        step_btn = 1'b1;
        tick(18);
        chk("step_pre_en", {31'd0, en}, 32'd0);
        tick(1);
        for (int i = 0; i < n_en; i++) begin
            chk("step_en", {31'd0, en}, 32'd1);
            chk("step_running", {31'd0, running}, 32'd1);
            tick(1);
        end
        chk("step_end_en", {31'd0, en}, 32'd0);
        chk("step_end_running", {31'd0, running}, 32'd0);
        chk("step_edge_cnt", {16'd0, edge_cnt}, {16'd0, exp_cnt});
        step_btn = 1'b0;
        tick(20);
        chk("step_settle_en", {31'd0, en}, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nrst     = 1'b0;
        run_req  = 1'b0;
        halt_req = 1'b0;
        step_btn = 1'b0;
        step_n   = 8'd0;
        cpu_hlt  = 1'b0;
        run_req4 = 1'b0;

        // Reset state.
        tick(2);
        chk("rst_en", {31'd0, en}, 32'd0);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_edge_cnt", {16'd0, edge_cnt}, 32'd0);
        nrst = 1'b1;
        tick(3);
        chk("idle_en", {31'd0, en}, 32'd0);

        // Bouncing button never holds a level long enough to be accepted.
        for (int i = 0; i < 40; i++) begin
            step_btn = ((i / 3) % 2) == 1;
            tick(1);
            chk("bounce_en", {31'd0, en}, 32'd0);
        end
        step_btn = 1'b0;
        tick(20);
        chk("bounce_edge_cnt", {16'd0, edge_cnt}, 32'd0);

        // Bursts of 3 and of 0 (treated as 1).
        do_step(8'd3, 3, 16'd3);
        do_step(8'd0, 1, 16'd4);

        // Run, then CPU halt: enable drops at the third edge after assertion.
        run_req = 1'b1;
        tick(1);
        run_req = 1'b0;
        chk("run_en", {31'd0, en}, 32'd1);
        chk("run_running", {31'd0, running}, 32'd1);
        tick(4);
        cpu_hlt = 1'b1;
        tick(2);
        chk("hlt_lat_en", {31'd0, en}, 32'd1);
        tick(1);
        chk("hlt_en", {31'd0, en}, 32'd0);
        chk("hlt_running", {31'd0, running}, 32'd0);
        chk("hlt_edge_cnt", {16'd0, edge_cnt}, 32'd11);
        // run_req is refused while the CPU still asks to halt.
        run_req = 1'b1;
        tick(2);
        chk("hlt_block_run", {31'd0, en}, 32'd0);
        run_req = 1'b0;
        cpu_hlt = 1'b0;
        tick(3);

        // halt_req beats run_req and step pulse arriving together.
        halt_req = 1'b1;
        run_req  = 1'b1;
        step_n   = 8'd3;
        step_btn = 1'b1;
        tick(19);
        chk("prio_halt_en", {31'd0, en}, 32'd0);
        chk("prio_halt_running", {31'd0, running}, 32'd0);
        step_btn = 1'b0;
        run_req  = 1'b0;
        halt_req = 1'b0;
        tick(20);

        // run_req and step pulse together: RUN wins, no burst loaded.
        step_btn = 1'b1;
        tick(18);
        run_req = 1'b1;
        tick(1);
        run_req = 1'b0;
        chk("prio_run_en", {31'd0, en}, 32'd1);
        chk("prio_run_running", {31'd0, running}, 32'd1);
        chk("prio_run_rem", {24'd0, u_dut.rem_q}, 32'd0);
        tick(6);
        chk("prio_run_still_en", {31'd0, en}, 32'd1);
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        chk("prio_stop_en", {31'd0, en}, 32'd0);
        chk("prio_stop_edge_cnt", {16'd0, edge_cnt}, 32'd18);
        step_btn = 1'b0;
        tick(20);

        // Long burst aborted by halt_req after 50 enable cycles.
        step_n   = 8'd200;
        step_btn = 1'b1;
        tick(19);
        chk("long_en", {31'd0, en}, 32'd1);
        step_btn = 1'b0;
        tick(49);
        chk("long_en50", {31'd0, en}, 32'd1);
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        chk("long_abort_en", {31'd0, en}, 32'd0);
        chk("long_abort_running", {31'd0, running}, 32'd0);
        chk("long_abort_rem", {24'd0, u_dut.rem_q}, 32'd0);
        chk("long_abort_edge_cnt", {16'd0, edge_cnt}, 32'd68);
        tick(20);
        do_step(8'd2, 2, 16'd70);

        // 4-bit edge counter wraps after 17 edges.
        run_req4 = 1'b1;
        tick(1);
        run_req4 = 1'b0;
        chk("wrap_en", {31'd0, en4}, 32'd1);
        tick(17);
        chk("wrap_edge_cnt", {28'd0, edge_cnt4}, 32'd1);
        chk("wrap_running", {31'd0, running4}, 32'd1);

        // Reset mid-run clears everything before the next rising edge.
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_en", {31'd0, en4}, 32'd0);
        chk("arst_running", {31'd0, running4}, 32'd0);
        chk("arst_edge_cnt4", {28'd0, edge_cnt4}, 32'd0);
        chk("arst_edge_cnt", {16'd0, edge_cnt}, 32'd0);
        tick(2);
        chk("arst_hold_en", {31'd0, en4}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_clkstep_ctl
